// File: rtl/cpu_mem_arbiter.sv
// Merges the core's instruction and data SRAM ports onto a single sram-like bus
// with one outstanding transaction; data has priority, bounded by a starvation counter.
module cpu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int unsigned   CW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [1:0]    state_q,      state_d;
    logic          grant_data_q, grant_data_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          mem_req_q,    mem_req_d;
    logic          mem_wr_q,     mem_wr_d;
    logic [3:0]    mem_wstrb_q,  mem_wstrb_d;
    logic [31:0]   mem_addr_q,   mem_addr_d;
    logic [31:0]   mem_wdata_q,  mem_wdata_d;
    logic          inst_done_q,  inst_done_d;
    logic          data_done_q,  data_done_d;
    logic [31:0]   inst_rdata_q, inst_rdata_d;
    logic [31:0]   data_rdata_q, data_rdata_d;
    logic          busy_q,       busy_d;
    logic          finish_s;

    // Arbitration, bus handshake sequencing and completion capture.
    always_comb begin
        state_d      = state_q;
        grant_data_d = grant_data_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        finish_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_req && (!inst_req || (starve_cnt_q < STARVE_MAX))) begin
                    state_d      = ST_ADDR;
                    grant_data_d = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_wr_d     = |data_wen;
                    mem_wstrb_d  = data_wen;
                    mem_addr_d   = data_addr;
                    mem_wdata_d  = data_wdata;
                    // With inst waiting the count is below the limit here, so +1 saturates at it.
                    if (inst_req) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (inst_req) begin
                    state_d      = ST_ADDR;
                    grant_data_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_wr_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    mem_addr_d   = inst_addr;
                    mem_wdata_d  = 32'h0000_0000;
                    starve_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DATA;
                    finish_s  = mem_data_ok;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_DATA: begin
                finish_s = mem_data_ok;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (finish_s) begin
            state_d = ST_IDLE;
            if (grant_data_q) begin
                data_done_d = 1'b1;
                if (!mem_wr_q) begin
                    data_rdata_d = mem_rdata;
                end else begin
                    data_rdata_d = data_rdata_q;
                end
            end else begin
                inst_done_d  = 1'b1;
                inst_rdata_d = mem_rdata;
            end
        end else begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_data_q <= 1'b0;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0000;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= 32'h0000_0000;
            data_rdata_q <= 32'h0000_0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_data_q <= grant_data_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign inst_done  = inst_done_q;
    assign data_rdata = data_rdata_q;
    assign data_done  = data_done_q;
    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scenario-task bench for cpu_mem_arbiter: directed cases plus a randomized run
// against a transaction-level reference model.
module tb_cpu_mem_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_done(data_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wen = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        tick; tick; tick;
        n_checks++;
        if ({mem_req, mem_wr, mem_wstrb, busy, inst_done, data_done} !== 9'b0)
            $display("FAIL reset_ctrl got %b exp 0", {mem_req, mem_wr, mem_wstrb, busy, inst_done, data_done});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'h0)
            $display("FAIL reset_data got %h %h %h %h exp 0", mem_addr, mem_wdata, inst_rdata, data_rdata);
        else n_pass++;
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_inst_read;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        tick;
        n_checks++;
        if ({mem_req, mem_wr, mem_wstrb, busy, mem_addr} !== {1'b1, 1'b0, 4'b0000, 1'b1, 32'hBFC0_0000})
            $display("FAIL inst_bus got req=%b wr=%b st=%b busy=%b a=%h exp 1 0 0000 1 bfc00000",
                     mem_req, mem_wr, mem_wstrb, busy, mem_addr);
        else n_pass++;
        mem_addr_ok = 1'b1;
        tick;
        n_checks++;
        if ({mem_req, inst_done} !== 2'b00) $display("FAIL inst_addr_ok got req=%b done=%b exp 0 0", mem_req, inst_done);
        else n_pass++;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001;
        tick;
        n_checks++;
        if ({inst_done, data_done, inst_rdata} !== {1'b1, 1'b0, 32'h3C08_0001})
            $display("FAIL inst_done got done=%b/%b rdata=%h exp 1/0 3c080001", inst_done, data_done, inst_rdata);
        else n_pass++;
        inst_req = 1'b0; mem_data_ok = 1'b0;
        tick;
        n_checks++;
        if ({inst_done, busy, mem_req} !== 3'b000) $display("FAIL inst_after got %b exp 000", {inst_done, busy, mem_req});
        else n_pass++;
    endtask

    task automatic test_data_write;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0FFC; data_wdata = 32'h0;
        tick;
        n_checks++;
        if ({mem_req, mem_wr, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'b0000, 32'h8000_0FFC})
            $display("FAIL dread_bus got req=%b wr=%b st=%b a=%h", mem_req, mem_wr, mem_wstrb, mem_addr);
        else n_pass++;
        mem_addr_ok = 1'b1;
        tick;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        n_checks++;
        if ({data_done, data_rdata} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL dread_done got done=%b rdata=%h exp 1 cafef00d", data_done, data_rdata);
        else n_pass++;
        data_req = 1'b0; mem_data_ok = 1'b0;
        tick;
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_1000; data_wdata = 32'h1234_ABCD;
        tick;
        n_checks++;
        if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'h1234_ABCD})
            $display("FAIL dwrite_bus got req=%b wr=%b st=%b a=%h d=%h", mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata);
        else n_pass++;
        mem_addr_ok = 1'b1;
        tick;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
        tick;
        n_checks++;
        if ({data_done, inst_done, data_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D})
            $display("FAIL dwrite_done got done=%b/%b rdata=%h exp 1/0 cafef00d", data_done, inst_done, data_rdata);
        else n_pass++;
        data_req = 1'b0; data_wen = 4'b0000; mem_data_ok = 1'b0;
        tick;
    endtask

    task automatic test_starvation;
        logic [5:0] order;
        logic [5:0] exp_order;
        logic       pend;
        int         ng;
        exp_order = 6'b011011;
        order = 6'b0; pend = 1'b0; ng = 0;
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_addr = 32'h0000_2000; data_wen = 4'b0000;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick;
            mem_data_ok = pend;
            pend = mem_req;
            mem_addr_ok = mem_req;
            mem_rdata = 32'(c);
            if (mem_req === 1'b1) begin
                order[ng] = (mem_addr == 32'h0000_2000);
                ng++;
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        tick;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        tick;
        mem_data_ok = 1'b0;
        tick;
        n_checks++;
        if (ng != 6) $display("FAIL starve_grants got %0d exp 6", ng);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (order[i] !== exp_order[i]) $display("FAIL starve_order[%0d] got data=%b exp %b", i, order[i], exp_order[i]);
            else n_pass++;
        end
    endtask

    task automatic test_addr_stall;
        inst_req = 1'b1; inst_addr = 32'h0040_0000;
        tick;
        inst_addr = 32'h0040_0010;
        mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mem_req, mem_wr, mem_wstrb, mem_addr, inst_done, busy} !== {1'b1, 1'b0, 4'b0000, 32'h0040_0000, 1'b0, 1'b1})
                $display("FAIL stall[%0d] got req=%b wr=%b st=%b a=%h done=%b busy=%b",
                         i, mem_req, mem_wr, mem_wstrb, mem_addr, inst_done, busy);
            else n_pass++;
            tick;
        end
        mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
        tick;
        n_checks++;
        if ({mem_req, inst_done} !== 2'b00) $display("FAIL stall_accept got req=%b done=%b exp 0 0", mem_req, inst_done);
        else n_pass++;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_BEEF;
        tick;
        n_checks++;
        if ({inst_done, inst_rdata} !== {1'b1, 32'h0000_BEEF})
            $display("FAIL stall_done got done=%b rdata=%h exp 1 0000beef", inst_done, inst_rdata);
        else n_pass++;
        inst_req = 1'b0; mem_data_ok = 1'b0;
        tick;
    endtask

    task automatic test_same_cycle;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_2000;
        tick;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        n_checks++;
        if ({data_done, data_rdata, busy, mem_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0})
            $display("FAIL same_cycle got done=%b rdata=%h busy=%b req=%b exp 1 deadbeef 0 0",
                     data_done, data_rdata, busy, mem_req);
        else n_pass++;
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        tick;
        n_checks++;
        if (data_done !== 1'b0) $display("FAIL same_cycle_pulse got %b exp 0", data_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        inst_req = 1'b1; inst_addr = 32'h0040_0100;
        tick;
        mem_addr_ok = 1'b1;
        tick;
        resetn = 1'b0; mem_addr_ok = 1'b0; inst_req = 1'b0;
        tick;
        n_checks++;
        if ({mem_req, busy, inst_done, inst_rdata, data_rdata} !== 67'h0)
            $display("FAIL rst_mid got req=%b busy=%b done=%b ir=%h dr=%h", mem_req, busy, inst_done, inst_rdata, data_rdata);
        else n_pass++;
        resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h9999_9999;
        tick;
        n_checks++;
        if ({inst_done, data_done, mem_req, busy, inst_rdata} !== 36'h0)
            $display("FAIL rst_late got done=%b/%b req=%b busy=%b ir=%h", inst_done, data_done, mem_req, busy, inst_rdata);
        else n_pass++;
        mem_data_ok = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic        m_busy, m_req, m_gd, m_wr, m_idone, m_ddone, fin;
        logic [31:0] m_addr, m_wdata, m_ird, m_drd;
        logic [3:0]  m_wstrb;
        int          streak, grants;
        m_busy = 1'b0; m_req = 1'b0; m_gd = 1'b0; m_wr = 1'b0; m_idone = 1'b0; m_ddone = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_ird = 32'h0; m_drd = 32'h0; m_wstrb = 4'h0;
        streak = 0; grants = 0;
        for (int c = 0; c < 3000; c++) begin
            n_checks++;
            if ({mem_req, busy} !== {m_req, m_busy})
                $display("FAIL rnd_ctrl c=%0d got req=%b busy=%b exp %b %b", c, mem_req, busy, m_req, m_busy);
            else n_pass++;
            if (m_req) begin
                n_checks++;
                if ({mem_addr, mem_wr, mem_wstrb} !== {m_addr, m_wr, m_wstrb} || (m_wr && mem_wdata !== m_wdata))
                    $display("FAIL rnd_bus c=%0d got a=%h wr=%b st=%b d=%h exp %h %b %b %h",
                             c, mem_addr, mem_wr, mem_wstrb, mem_wdata, m_addr, m_wr, m_wstrb, m_wdata);
                else n_pass++;
            end
            n_checks++;
            if ({inst_done, data_done, inst_rdata, data_rdata} !== {m_idone, m_ddone, m_ird, m_drd})
                $display("FAIL rnd_resp c=%0d got %b%b %h %h exp %b%b %h %h",
                         c, inst_done, data_done, inst_rdata, data_rdata, m_idone, m_ddone, m_ird, m_drd);
            else n_pass++;

            // CPU side: drop on done, occasionally withdraw an ungranted request, raise new ones.
            if (m_idone) inst_req = 1'b0;
            if (m_ddone) data_req = 1'b0;
            if (inst_req && !(m_busy && !m_gd) && $urandom_range(0, 9) == 0) inst_req = 1'b0;
            if (data_req && !(m_busy && m_gd) && $urandom_range(0, 9) == 0) data_req = 1'b0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1'b1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1'b1; data_addr = $urandom; data_wdata = $urandom;
                data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            end

            // Bus side: random acceptance/response, with noise where the arbiter must ignore it.
            mem_rdata = $urandom;
            if (m_req) begin
                mem_addr_ok = ($urandom_range(0, 1) == 1);
                mem_data_ok = mem_addr_ok ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            end else if (m_busy) begin
                mem_addr_ok = ($urandom_range(0, 3) == 0);
                mem_data_ok = ($urandom_range(0, 1) == 1);
            end else begin
                mem_addr_ok = ($urandom_range(0, 3) == 0);
                mem_data_ok = ($urandom_range(0, 3) == 0);
            end

            m_idone = 1'b0; m_ddone = 1'b0;
            if (!m_busy) begin
                if (data_req && (!inst_req || streak < LIMIT)) begin
                    m_busy = 1'b1; m_req = 1'b1; m_gd = 1'b1; grants++;
                    m_addr = data_addr; m_wdata = data_wdata; m_wstrb = data_wen; m_wr = (data_wen != 4'b0000);
                    streak = inst_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                end else if (inst_req) begin
                    m_busy = 1'b1; m_req = 1'b1; m_gd = 1'b0; grants++;
                    m_addr = inst_addr; m_wstrb = 4'b0000; m_wr = 1'b0;
                    streak = 0;
                end
            end else begin
                fin = m_req ? (mem_addr_ok && mem_data_ok) : mem_data_ok;
                if (m_req && mem_addr_ok) m_req = 1'b0;
                if (fin) begin
                    m_busy = 1'b0;
                    if (m_gd) begin
                        m_ddone = 1'b1;
                        if (!m_wr) m_drd = mem_rdata;
                    end else begin
                        m_idone = 1'b1;
                        m_ird = mem_rdata;
                    end
                end
            end
            tick;
        end
        n_checks++;
        if (grants < 100) $display("FAIL rnd_activity got %0d grants exp >= 100", grants);
        else n_pass++;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    initial begin
        test_reset;
        test_inst_read;
        test_data_write;
        test_starvation;
        test_addr_stall;
        test_same_cycle;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the CPU core's instruction and data SRAM ports.
- Merges the two channels onto a single sram-like memory bus (req/addr_ok/data_ok handshake) with at most one outstanding transaction.
- Data channel has priority; a starvation counter guarantees instruction fetch progress.
- Per-channel done pulses and registered read data let the core stall until its access completes.

Parameters:
- STARVE_LIMIT, 2, consecutive data grants allowed while inst_req is pending before inst is forced to win.

Ports:
- clk  in  1  clock, all logic on posedge
- resetn  in  1  synchronous reset, active low
- inst_req  in  1  instruction read request, held until inst_done
- inst_addr  in  32  instruction fetch address
- inst_rdata  out  32  fetched word, valid with inst_done, held until next inst_done
- inst_done  out  1  one-cycle completion pulse for inst channel
- data_req  in  1  data request, held until data_done
- data_wen  in  4  byte write strobes; 0 = read
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_rdata  out  32  load word, valid with data_done, held until next data_done
- data_done  out  1  one-cycle completion pulse for data channel
- mem_req  out  1  bus request
- mem_wr  out  1  1 = write
- mem_wstrb  out  4  byte strobes (0 on reads)
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_addr_ok  in  1  request accepted (sampled only while mem_req=1)
- mem_data_ok  in  1  response/write ack
- mem_rdata  in  32  read data, valid with mem_data_ok
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ADDR, DATA. All outputs registered.
- Reset values: state IDLE, mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, inst_done 0, data_done 0, inst_rdata 0, data_rdata 0, busy 0, starve counter 0, grant register = inst.
- IDLE: if data_req and (!inst_req or starve_cnt < STARVE_LIMIT), grant data. Else if inst_req, grant inst. Latch addr, wdata, and wr = |data_wen (inst: wr 0, wstrb 0) into bus registers. Go to ADDR with mem_req=1 next cycle.
- Starve counter:
  - increments on a data grant while inst_req=1;
  - clears on any inst grant, or on any grant with inst_req=0;
  - saturates at STARVE_LIMIT.
- ADDR: mem_req and bus fields held stable.
  - On mem_addr_ok: mem_req drops next cycle and state goes to DATA.
  - If mem_data_ok is also high in the same cycle, the transaction completes directly (see DATA).
- DATA: on mem_data_ok, pulse the granted channel's done next cycle. Capture mem_rdata into that channel's rdata only on reads; writes leave data_rdata unchanged. Return to IDLE.
- Minimum latency: req sampled in IDLE at cycle 0 → mem_req at 1 → addr_ok at 1 → data_ok at 2 → done at 3.
- The earliest next grant is in the cycle done is visible. The core must drop or replace req on the done cycle; a req still high then is taken as a new request.
- mem_data_ok while in IDLE or ADDR without a prior addr_ok is ignored.
- A CPU req dropped before grant creates no transaction. A req dropped after grant does not cancel: the bus transaction completes and done still pulses.
- Reset mid-transaction returns to IDLE with all reset values next cycle. Any in-flight bus response arriving after reset is ignored.
- Never more than one transaction outstanding; the other channel waits in IDLE arbitration.

Test Plan:
- inst_req=1, addr 0xBFC00000; bus gives addr_ok on first mem_req cycle and data_ok next with rdata 0x3C080001 → inst_done one pulse at cycle 3, inst_rdata=0x3C080001, mem_wr=0.
- data_req=1, wen=4'b0011, addr 0x80001000, wdata 0x1234ABCD → mem_wr=1, wstrb=0011, addr/wdata match. data_done pulses after data_ok; data_rdata unchanged.
- inst_req and data_req both high from reset release, data_req reasserted after each done, STARVE_LIMIT=2 → grant order data, data, inst, data, data, inst.
- Bus holds addr_ok low 5 cycles → mem_req and all bus fields stable for 5+ cycles, no done until data_ok.
- addr_ok and data_ok asserted in the same cycle with rdata 0xDEADBEEF → done next cycle, rdata=0xDEADBEEF, no DATA-state cycle.
- resetn=0 for one cycle while in DATA, then a late data_ok → no done pulse, mem_req 0, busy 0, rdata registers 0.
